// File: rtl/rr_arbiter_pkg.sv
// Shared sizing and one-hot/index helpers for the round-robin arbiter.
// Helpers work on MAX_W-wide vectors; callers size-cast to their own width.
package rr_arbiter_pkg;

  localparam int MAX_W = 6;
  localparam int MAX_N = 1 << MAX_W;

  function automatic int num_req(input int w);
    return 1 << w;
  endfunction

  function automatic logic [MAX_W-1:0] onehot_to_index(input logic [MAX_N-1:0] onehot);
    logic [MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (onehot[i]) idx |= MAX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_N-1:0] index_to_onehot(input logic [MAX_W-1:0] idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between shared-resource clients and the arbiter.
interface rr_arbiter_if
  import rr_arbiter_pkg::*;
#(
  parameter int W = 2
);
  localparam int N = num_req(W);

  logic [N-1:0] req;
  logic [N-1:0] gnt;

  modport master (output req, input gnt);
  modport slave  (input req, output gnt);
endinterface

// File: rtl/rr_prio_enc.sv
// Fixed-priority find-first-set: lowest set bit of vec wins.
module rr_prio_enc
  import rr_arbiter_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [(1<<W)-1:0] vec,
  output logic              valid,
  output logic [W-1:0]      idx
);
  localparam int N = num_req(W);

  logic [N-1:0] lowest;

  // Two's-complement trick isolates the lowest set bit as a one-hot.
  assign lowest = vec & (~vec + N'(1));
  assign valid  = |vec;
  assign idx    = W'(onehot_to_index(MAX_N'(lowest)));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 2**W requesters with a registered one-hot grant.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  rr_arbiter_if.slave  bus
);
  localparam int N = num_req(W);

  logic [N-1:0] gnt_q;
  logic [N-1:0] req_rot;
  logic [W-1:0] ptr;
  logic [W-1:0] base;
  logic [W-1:0] rot_idx;
  logic [W-1:0] winner;
  logic         found;

  // Rotated bit 0 is requester ptr+1, so the fixed-priority search starts there.
  assign base = ptr + W'(1);

  always_comb begin
    // NOTE: default assignment first so no path can leave req_rot unassigned and infer a latch.
    req_rot = '0;
    for (int i = 0; i < N; i++) begin
      req_rot[i] = bus.req[W'(i) + base];
    end
  end

  rr_prio_enc #(.W(W)) u_prio_enc (
    .vec   (req_rot),
    .valid (found),
    .idx   (rot_idx)
  );

  assign winner = rot_idx + base;

  // ptr holds its value while idle so fairness history survives gaps in traffic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      gnt_q <= '0;
      ptr   <= '1;
    end else if (found) begin
      gnt_q <= N'(index_to_onehot(MAX_W'(winner)));
      ptr   <= winner;
    end else begin
      gnt_q <= '0;
    end
  end

  assign bus.gnt = gnt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomised scoreboard bench for rr_arbiter against a search-order reference model.
module tb_rr_arbiter;
  localparam int W = 2;
  localparam int N = 1 << W;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
  } exp_t;

  logic clock;
  logic reset;
  exp_t sb[$];
  int   n_vec;
  int   n_err;
  int   m_ptr;
  int   wait_cnt [N];

  rr_arbiter_if #(.W(W)) bus ();

  rr_arbiter #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan ptr+1 .. ptr+N modulo N, first requester found wins.
  function automatic logic [N-1:0] model_step(input logic [N-1:0] r);
    for (int off = 1; off <= N; off++) begin
      int k;
      k = (m_ptr + off) % N;
      if (r[k]) begin
        m_ptr = k;
        return N'(1) << k;
      end
    end
    return '0;
  endfunction

  task automatic apply(input logic [N-1:0] v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      exp_t e;
      @(negedge clock);
      bus.req = v;
      e.req = v;
      e.gnt = model_step(v);
      sb.push_back(e);
    end
  endtask

  // Monitor: one expected entry per sampling edge, checked just after the edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clock);
      #1;
      if (!reset) begin
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt", bus.gnt, e.gnt);
        check("onehot0", $onehot0(bus.gnt), 1);
        check("gnt_within_req", (bus.gnt & ~e.req) == '0, 1);
        for (int i = 0; i < N; i++) begin
          if (e.req[i] && !bus.gnt[i]) wait_cnt[i]++;
          else wait_cnt[i] = 0;
          if (e.req[i]) check("starvation_bound", wait_cnt[i] < N, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] v;
    n_vec = 0;
    n_err = 0;
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    reset   = 1'b0;
    bus.req = '1;

    repeat (3) begin
      @(negedge clock);
      check("reset_gnt", bus.gnt, 0);
    end
    @(posedge clock);
    #3 reset = 1'b1;

    apply('1, 5);

    for (int i = 0; i < N; i++) apply(N'(1) << i, 2);
    apply('0, 2);

    apply(4'b0010, 1);
    apply(4'b1001, 3);

    for (int i = 0; i < 16; i++) apply(N'(i), 2);
    for (int i = 15; i >= 0; i--) apply(N'(i), 2);
    for (int i = 0; i < 48; i++) apply(N'(i % 16), 2);

    apply(4'b0100, 1);
    apply('0, 5);
    apply('1, 1);

    for (int i = 0; i < 20; i++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      apply(v, 10);
    end
    for (int i = 0; i < 16; i++) begin
      v = N'(i ^ (i >> 1));
      apply(v, 10);
    end

    apply('1, 3);
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check("async_reset_gnt", bus.gnt, 0);
    @(posedge clock);
    #1 check("reset_hold_gnt", bus.gnt, 0);
    m_ptr = N - 1;
    #2 reset = 1'b1;
    apply('1, 5);

    repeat (3) @(posedge clock);
    #2 check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Parameterised round-robin arbiter for N = 2**W requesters.
- Every clock it samples the request vector and issues a registered grant.
- The grant is one-hot, or zero when nothing is requested.
- Priority rotates so the requester after the most recent grantee is served first; any continuously asserting requester is granted within N cycles.
- Sits between shared-resource clients and the resource mux; the gnt vector drives the mux selects directly.

Parameters:
- W, default 2: log2 of requester count. N = 2**W requesters. Legal range W >= 1.

Ports:
- clock, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req, input, 2**W: request vector; bit i = requester i wants the resource; level-sensitive, sampled every rising edge.
- gnt, output, 2**W: registered grant vector; one-hot or all-zero.

Behaviour:
- State: gnt register (N bits); last-grant pointer ptr (W bits).
- Reset (reset low, asynchronous assert, synchronous-safe release):
  - gnt = 0.
  - ptr = N-1, so the first search after reset starts at index 0.
- Each rising edge with reset high:
  - Search order: ptr+1, ptr+2, ..., ptr+N, indices modulo N (wrap-around).
  - The first index k with req[k]=1 wins.
  - gnt <= one-hot(k); ptr <= k.
- No request (req=0): gnt <= 0; ptr unchanged, so fairness history is kept across idle periods.
- Latency: gnt reflects req sampled at the previous edge (1 cycle). There is no combinational path from req to gnt.
- Continuous requests: the grant moves every cycle to the next active requester.
  - Single active requester: it is re-granted every cycle. Search wraps to ptr itself at position ptr+N.
  - All N requesting: grant rotates 0,1,...,N-1,0,... one step per cycle.
- Request drop: a requester deasserting is not granted at the next edge; no lock or hold behaviour.
- Invariants:
  - gnt has at most one bit set.
  - gnt[i]=1 implies req[i] was 1 at the sampling edge.
  - A requester held high is granted within N cycles.
- Reset mid-operation: gnt clears immediately, asynchronously. Arbitration restarts from index 0 after release.
- Rotation implementation:
  - Mask or rotate req by ptr, apply a fixed-priority (lowest-index-first) find-first, un-rotate.
  - Doubled-vector or mask-plus-unmasked fallback techniques are both acceptable.
  - Must be fully parameterised in W, with no hardcoded N.

Decomposition:
- Shared package holds:
  - function/localparam computing N = 2**W;
  - a onehot-to-index helper;
  - an index-to-onehot helper.
- One sub-module: rr_prio_enc, a combinational fixed-priority find-first-set over N bits.
  - Outputs: valid and W-bit index.
  - Instantiated once in the rotated domain.
- The rr_arbiter top holds the rotate/un-rotate logic, ptr and the gnt register.

Test Plan:
- Reset: reset low with req=4'b1111 -> gnt=0 while low; after release, the next edges give gnt 0001, 0010, 0100, 1000, 0001.
- One-hot shift (W=2), each value held 2 cycles:
  - req 0001 -> 0010 -> 0100 -> 1000 -> 0000.
  - gnt follows one cycle later with the same one-hot value, then 0000; never two bits set.
- Fairness with gaps:
  - ptr=1 (last gnt 0010), req=1001 -> next gnt 1000, then 0001, then 1000.
  - Wrap-around from index 3 back to 0 is exercised.
- Counter sweep: req up-count 0..15, down-count, and wrap twice, each value held 2 cycles -> every cycle gnt is one-hot within the previous req, or 0 when req=0.
- Idle preserves pointer: grant 0100, then req=0 for 5 cycles (gnt=0), then req=1111 -> first gnt 1000.
- Random and Gray-code sequences (20 random values, 16 Gray codes, each held 10 cycles):
  - Scoreboard against a reference pointer model.
  - Check exact gnt sequence, one-cycle latency, and starvation bound N.
